// File: rtl/vc_random_num_gen_mc_if.sv
// Stream and reseed bundle for vc_random_num_gen_mc.
//   master (the generator): drives val/out, receives rdy and the reseed request
//   slave  (the consumer) : drives rdy and the reseed request, receives val/out
// Signals:
//   seed_en   - reseed request this cycle
//   seed_chan - channel to reseed
//   seed_data - new 32-bit LFSR state
//   rdy       - per-channel consumer ready
//   val       - per-channel value valid
//   out       - channel c occupies bits [c*p_nbits +: p_nbits]
interface vc_random_num_gen_mc_if #(
  parameter int p_nbits     = 16,
  parameter int p_nchannels = 4
);
  localparam int chan_w = (p_nchannels > 1) ? $clog2(p_nchannels) : 1;

  logic                           seed_en;
  logic [chan_w-1:0]              seed_chan;
  logic [31:0]                    seed_data;
  logic [p_nchannels-1:0]         rdy;
  logic [p_nchannels-1:0]         val;
  logic [p_nchannels*p_nbits-1:0] out;

  modport master (
    output val, out,
    input  rdy, seed_en, seed_chan, seed_data
  );

  modport slave (
    input  val, out,
    output rdy, seed_en, seed_chan, seed_data
  );
endinterface

// File: rtl/vc_random_num_gen_mc.sv
// Multi-channel pseudo-random number source.
// Each channel owns a 32-bit right-shift Galois LFSR and offers its low
// p_nbits bits on a val/rdy stream; the LFSR advances only when the value is
// consumed. Any channel can be reseeded at runtime; a zero seed is replaced by
// 1 so the register never locks up.
// Ports:
//   clk   - clock, all state changes on posedge
//   reset - asynchronous, active-low
//   bus   - master side of vc_random_num_gen_mc_if (seed_*, rdy in; val, out out)
module vc_random_num_gen_mc #(
  parameter int          p_nbits     = 16,
  parameter int          p_nchannels = 4,
  parameter logic [31:0] p_seed      = 32'hdeadbeef,
  parameter logic [31:0] p_poly      = 32'h80200003
) (
  input  logic                   clk,
  input  logic                   reset,
  vc_random_num_gen_mc_if.master bus
);

  // Per-channel reset state: base seed spread by the golden-ratio constant so
  // channels start far apart yet stay reproducible from one base seed.
  function automatic logic [31:0] init_state(input int c);
    logic [31:0] s;
    s = p_seed ^ (32'(c) * 32'h9E3779B9);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? p_poly : 32'h0);
  endfunction

  function automatic logic [31:0] nonzero(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  logic [p_nchannels-1:0][31:0] state;
  logic [p_nchannels-1:0]       val_q;
  logic [p_nchannels-1:0]       reseed_sel;

  // Out-of-range channel numbers simply match nothing.
  always_comb begin
    reseed_sel = '0;
    for (int c = 0; c < p_nchannels; c++) begin
      reseed_sel[c] = bus.seed_en && (int'(bus.seed_chan) == c);
    end
  end

  // val is cleared by reset and by a reseed, and is set again on the next
  // edge. That one rule yields the warm-up cycle after reset, the one-cycle
  // gap after a reseed, and the extended gap for back-to-back reseeds.
  // A reseed overrides a simultaneous fire on the same channel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < p_nchannels; c++) begin
        state[c] <= init_state(c);
      end
      val_q <= '0;
    end else begin
      for (int c = 0; c < p_nchannels; c++) begin
        if (reseed_sel[c]) begin
          state[c] <= nonzero(bus.seed_data);
          val_q[c] <= 1'b0;
        end else begin
          if (val_q[c] && bus.rdy[c]) begin
            state[c] <= lfsr_next(state[c]);
          end
          val_q[c] <= 1'b1;
        end
      end
    end
  end

  assign bus.val = val_q;

  for (genvar c = 0; c < p_nchannels; c++) begin : g_out
    assign bus.out[c*p_nbits +: p_nbits] = state[c][p_nbits-1:0];
  end

endmodule

// File: tb/tb_vc_random_num_gen_mc.sv
// Bench for vc_random_num_gen_mc with default parameters.
// A stimulus process drives inputs just after each rising edge and advances a
// reference model; per-cycle expectations and consumed values go into queues
// that a monitor drains on the falling edge.
module tb_vc_random_num_gen_mc;
  localparam int          NC   = 4;
  localparam int          NB   = 16;
  localparam int          CW   = 2;
  localparam logic [31:0] SEED = 32'hdeadbeef;
  localparam logic [31:0] POLY = 32'h80200003;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vc_random_num_gen_mc_if #(.p_nbits(NB), .p_nchannels(NC)) bus();

  vc_random_num_gen_mc #(
    .p_nbits(NB), .p_nchannels(NC), .p_seed(SEED), .p_poly(POLY)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_state [NC];
  bit          m_val   [NC];

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s / 2) ^ (((s % 2) == 1) ? POLY : 32'h0);
  endfunction

  function automatic logic [31:0] init_of(input int c);
    logic [31:0] cc, s;
    cc = c;
    s  = SEED ^ (cc * 32'h9E3779B9);
    return (s == 0) ? 32'h1 : s;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_state[c] = init_of(c);
      m_val[c]   = 0;
    end
  endtask

  // Apply what the DUT saw at the edge that just happened.
  task automatic model_edge();
    if (!reset) begin
      model_reset();
    end else begin
      for (int c = 0; c < NC; c++) begin
        if (bus.seed_en && bus.seed_chan == CW'(c)) begin
          m_state[c] = (bus.seed_data == 0) ? 32'h1 : bus.seed_data;
          m_val[c]   = 0;
        end else if (m_val[c] && bus.rdy[c]) begin
          m_state[c] = lfsr_step(m_state[c]);
        end else begin
          m_val[c] = 1;
        end
      end
    end
  endtask

  typedef struct {
    logic [NC-1:0]    v;
    logic [NC*NB-1:0] o;
  } item_t;

  item_t         cyc_q [$];
  logic [NB-1:0] fire_q [NC][$];

  task automatic step(input logic [NC-1:0] r, input logic se, input logic [CW-1:0] sc,
                      input logic [31:0] sd, input logic rn);
    item_t it;
    @(posedge clk);
    #1;
    model_edge();
    bus.rdy       = r;
    bus.seed_en   = se;
    bus.seed_chan = sc;
    bus.seed_data = sd;
    reset         = rn;
    if (!rn) model_reset();
    for (int c = 0; c < NC; c++) begin
      it.v[c]          = m_val[c];
      it.o[c*NB +: NB] = m_state[c][NB-1:0];
      if (rn && m_val[c] && r[c] && !(se && sc == CW'(c)))
        fire_q[c].push_back(m_state[c][NB-1:0]);
    end
    cyc_q.push_back(it);
  endtask

  function automatic logic [NB-1:0] ch(input int c);
    return bus.out[c*NB +: NB];
  endfunction

  // ---------------- monitor ----------------
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (cyc_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL cycle_queue: got empty expected an entry");
      end else begin
        it = cyc_q.pop_front();
        check("val", 64'(bus.val), 64'(it.v));
        check("out", 64'(bus.out), 64'(it.o));
      end
      for (int c = 0; c < NC; c++) begin
        if (reset && bus.val[c] && bus.rdy[c] && !(bus.seed_en && bus.seed_chan == CW'(c))) begin
          if (fire_q[c].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL fire_ch%0d: got unexpected consumption of %h expected none", c, ch(c));
          end else begin
            check($sformatf("fire_ch%0d", c), 64'(ch(c)), 64'(fire_q[c].pop_front()));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [NB-1:0] run_a [12];
  logic [NB-1:0] run_b [12];

  initial begin
    reset         = 1'b0;
    bus.rdy       = '0;
    bus.seed_en   = 1'b0;
    bus.seed_chan = '0;
    bus.seed_data = '0;
    model_reset();

    // Reset and warm-up
    step('0, 0, 0, 0, 0);
    step('0, 0, 0, 0, 0);
    check("reset_val", 64'(bus.val), 64'h0);
    step('0, 0, 0, 0, 1);
    check("warmup_val", 64'(bus.val), 64'h0);
    step('0, 0, 0, 0, 1);
    check("ready_val", 64'(bus.val), 64'hf);
    check("init_ch0", 64'(ch(0)), 64'hbeef);
    check("init_ch1", 64'(ch(1)), 64'hc756);

    // Single advance then hold
    step(4'b0001, 0, 0, 0, 1);
    step('0, 0, 0, 0, 1);
    check("adv_ch0", 64'(ch(0)), 64'hdf74);
    check("adv_ch1", 64'(ch(1)), 64'hc756);
    for (int i = 0; i < 5; i++) begin
      step('0, 0, 0, 0, 1);
      check("hold_ch0", 64'(ch(0)), 64'hdf74);
    end
    step(4'b0001, 0, 0, 0, 1);
    step('0, 0, 0, 0, 1);
    check("adv2_ch0", 64'(ch(0)), 64'h6fba);

    // Reseed colliding with a fire
    step(4'b0001, 1, 0, 32'hdeadbeef, 1);
    step('0, 0, 0, 0, 1);
    check("reseed_val0", 64'(bus.val[0]), 64'h0);
    check("reseed_ch0", 64'(ch(0)), 64'hbeef);
    step('0, 0, 0, 0, 1);
    check("reseed_val1", 64'(bus.val[0]), 64'h1);
    check("reseed_hold_ch0", 64'(ch(0)), 64'hbeef);

    // Zero seed on channel 2
    step('0, 1, 2, 32'h0, 1);
    step('0, 0, 0, 0, 1);
    check("zero_seed_ch2", 64'(ch(2)), 64'h0001);
    step('0, 0, 0, 0, 1);
    check("zero_seed_val2", 64'(bus.val[2]), 64'h1);
    step(4'b0100, 0, 0, 0, 1);
    step('0, 0, 0, 0, 1);
    check("zero_seed_adv_ch2", 64'(ch(2)), 64'h0003);

    // Randomized traffic with occasional reseeds (some zero, some back-to-back)
    for (int i = 0; i < 400; i++) begin
      logic        se;
      logic [31:0] sd;
      se = ($urandom_range(0, 7) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      step(NC'($urandom), se, CW'($urandom_range(0, NC-1)), sd, 1);
    end

    // Run A from reset, mid-stream reset, run B must repeat it
    step('0, 0, 0, 0, 0);
    step('0, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      step('1, 0, 0, 0, 1);
      run_a[i] = ch(0);
    end
    check("run_a_first", 64'(run_a[0]), 64'hbeef);
    step('1, 0, 0, 0, 0);
    #1;
    check("async_val_drop", 64'(bus.val), 64'h0);
    check("async_ch0", 64'(ch(0)), 64'hbeef);
    step('0, 0, 0, 0, 0);
    step('0, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      step('1, 0, 0, 0, 1);
      run_b[i] = ch(0);
    end
    for (int i = 0; i < 12; i++)
      check($sformatf("rerun_%0d", i), 64'(run_b[i]), 64'(run_a[i]));

    step('0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    for (int c = 0; c < NC; c++)
      check($sformatf("fire_drain_ch%0d", c), 64'(fire_q[c].size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vc_random_num_gen_mc.md
Name: vc_random_num_gen_mc

Overview:
Multi-channel pseudo-random number source for test sources, random-delay sinks and traffic generators.
- Each of p_nchannels independent channels holds a 32-bit Galois LFSR.
- Each channel presents a p_nbits-wide value on a per-channel val/rdy stream and advances only when that value is consumed.
- Adds runtime reseeding with zero-lockup protection.
- Deterministic per-channel seeds are derived from a single base seed, so benches stay reproducible.

Parameters:
- p_nbits, 16, output width per channel; legal range 1..32.
- p_nchannels, 4, number of independent channels; legal range 1..16.
- p_seed, 32'hdeadbeef, base seed.
- p_poly, 32'h80200003, Galois right-shift feedback mask (x^32+x^22+x^2+x+1).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- seed_en  input  1  reseed request this cycle.
- seed_chan  input  $clog2(p_nchannels) (min 1)  channel to reseed.
- seed_data  input  32  new LFSR state.
- rdy  input  p_nchannels  per-channel consumer ready.
- val  output  p_nchannels  per-channel value valid.
- out  output  p_nchannels*p_nbits  channel c occupies bits [c*p_nbits +: p_nbits].

Behaviour:
- Reset value of channel c's state:
  - init_c = p_seed ^ (c * 32'h9E3779B9), truncated to 32 bits.
  - If init_c == 0, use 32'h1 instead.
- Reset is asserted asynchronously on reset==0:
  - all val clear to 0 immediately;
  - each state loads its init_c immediately.
- Release of reset is sampled at posedge. At the first posedge with reset==1, all val go to 1; the state is unchanged (one-cycle warm-up).
- out[c] = state_c[p_nbits-1:0] combinationally at all times, including during reset; it is meaningful only while val[c]==1.
- Advance rule, per channel, at posedge:
  - fire_c = val[c] & rdy[c].
  - On fire_c: state_c <= (state_c >> 1) ^ (state_c[0] ? p_poly : 0); val[c] stays 1.
  - Throughput is one value per cycle per channel while rdy is held high.
- Hold rule: when val[c]==0 or rdy[c]==0, state_c and out[c] hold. rdy with val==0 has no effect.
- Reseed, at posedge with seed_en==1:
  - The selected channel loads (seed_data==0 ? 32'h1 : seed_data).
  - val[seed_chan] is 0 for exactly the following cycle, then returns to 1.
  - Reseed takes priority over a simultaneous fire on the same channel; that fire is discarded and does not count as a consumption.
  - Other channels are unaffected and may fire in the same cycle.
  - seed_chan >= p_nchannels: the request is ignored.
  - seed_en during the post-reset warm-up cycle is honoured; val for that channel then stays 0 for one further cycle.
  - Back-to-back reseeds of the same channel keep val low until the cycle after the last one.
- The LFSR state is never 0; the period is 2^32-1 for the default p_poly.
- Channels are fully independent: no shared state except clk/reset.
- Reset asserted mid-stream aborts everything and returns to reset values; there is no partial advance.

Test Plan:
- Reset/warm-up, defaults: hold reset=0 for 2 cycles, release.
  - val=4'b0000 in the first cycle after release, 4'b1111 thereafter.
  - out ch0 = 16'hbeef; out ch1 = 16'hc756.
- Single advance: rdy=4'b0001 for one cycle.
  - ch0 out becomes 16'hdf74 (state 32'hEF76DF74).
  - ch1..ch3 unchanged (ch1 stays 16'hc756).
- Hold: rdy=0 for 5 cycles after the advance.
  - ch0 out stays 16'hdf74 throughout.
  - rdy=1 for one cycle then advances to the next LFSR value, matching the bench's software model.
- Reseed with collision: seed_en=1, seed_chan=0, seed_data=32'hdeadbeef, rdy[0]=1 in the same cycle.
  - Next cycle: val[0]=0, out ch0=16'hbeef.
  - Following cycle: val[0]=1, and 16'hbeef is still presented (no advance consumed).
- Zero seed: seed_data=0 on ch2.
  - out ch2 = 16'h0001 after load.
  - After one fire: state=32'h80200003, out=16'h0003.
- Mid-stream reset: assert reset while rdy=4'b1111 streaming.
  - val drops to 0 without waiting for a clock edge.
  - After release: ch0 = 16'hbeef again, and the sequence repeats identically to the first run.
